matching_pursuit_sweep: RTL



---
 rtl/matching_pursuit_sweep_pkg.sv | 36 +++
 rtl/fp_mac_accumulator.sv | 46 ++++
 rtl/matching_pursuit_sweep.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/matching_pursuit_sweep_pkg.sv
// Shared fixed-point types, sizing constants and saturation helpers for the matching-pursuit
// datapath.
package matching_pursuit_sweep_pkg;

  typedef logic signed [31:0] fp_32_t;

  localparam int unsigned FRAC_BITS               = 16;
  localparam int unsigned SIGNAL_SIZE_DEFAULT     = 4;
  localparam int unsigned DICTIONARY_SIZE_DEFAULT = 8;
  localparam int unsigned SIGNAL_ADDR_WIDTH       = 2;
  localparam int unsigned DICTIONARY_ADDR_WIDTH   = 5;
  localparam int unsigned ACC_W = 64 + $clog2(SIGNAL_SIZE_DEFAULT);

  // Wide enough to hold any accumulator this block can be built with.
  localparam int unsigned SAT_IN_W = 96;
  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 96'sh7FFF_FFFF;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -(96'sh8000_0000);

  function automatic fp_32_t sat32(input logic signed [SAT_IN_W-1:0] x);
    if (x > SAT_MAX) begin
      return 32'sh7FFF_FFFF;
    end else if (x < SAT_MIN) begin
      return 32'sh8000_0000;
    end else begin
      return x[31:0];
    end
  endfunction

  // 33-bit magnitude so that |0x80000000| = 2**31 is exact.
  function automatic logic [32:0] mag33(input fp_32_t x);
    logic signed [32:0] xe;
    xe = {x[31], x};
    return x[31] ? 33'(-xe) : 33'(xe);
  endfunction

endpackage

// File: rtl/fp_mac_accumulator.sv
// Registered signed multiply-accumulate: acc <= clear ? 0 : acc + a*b when en.
// Clear has priority over en.
module fp_mac_accumulator
  import matching_pursuit_sweep_pkg::*;
#(
  parameter int unsigned AccW = ACC_W
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   clear,
  input  logic                   en,
  input  logic [31:0]            a,
  input  logic [31:0]            b,
  output logic signed [AccW-1:0] acc
);

  logic signed [63:0]     a_ext;
  logic signed [63:0]     b_ext;
  logic signed [63:0]     product;
  logic signed [AccW-1:0] acc_q;
  logic signed [AccW-1:0] acc_d;

  assign a_ext   = {{32{a[31]}}, a};
  assign b_ext   = {{32{b[31]}}, b};
  assign product = a_ext * b_ext;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(AccW-64){product[63]}}, product};
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matching_pursuit_sweep.sv
// SWEEP stage: correlates the residual with every dictionary column and keeps the column
// with the largest |corr| (ties keep the lowest index).
module matching_pursuit_sweep
  import matching_pursuit_sweep_pkg::*;
#(
  parameter int unsigned M       = SIGNAL_SIZE_DEFAULT,
  parameter int unsigned N       = DICTIONARY_SIZE_DEFAULT,
  parameter int unsigned DICT_AW = DICTIONARY_ADDR_WIDTH,
  parameter int unsigned SIG_AW  = SIGNAL_ADDR_WIDTH,
  parameter int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [DICT_AW-1:0] dict_read_addr,
  input  logic [31:0]        dict_read_data,
  output logic [SIG_AW-1:0]  r_read_addr,
  input  logic [31:0]        r_read_data,
  output logic [IDX_W-1:0]   best_index,
  output logic [31:0]        best_corr
);

  localparam int unsigned AccW = 64 + $clog2(M);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StCompare} state_e;

  state_e             state_q, state_d;
  logic [SIG_AW-1:0]  i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   best_index_q, best_index_d;
  fp_32_t             best_corr_q, best_corr_d;
  logic               mac_clear, mac_en;

  logic signed [AccW-1:0]     acc;
  logic signed [SAT_IN_W-1:0] acc_wide;
  fp_32_t                     corr;
  logic                       corr_wins;

  fp_mac_accumulator #(
    .AccW (AccW)
  ) u_mac (
    .clock  (clock),
    .resetN (resetN),
    .clear  (mac_clear),
    .en     (mac_en),
    .a      (dict_read_data),
    .b      (r_read_data),
    .acc    (acc)
  );

  assign acc_wide  = {{(SAT_IN_W-AccW){acc[AccW-1]}}, acc};
  assign corr      = sat32(acc_wide >>> FRAC_BITS);
  assign corr_wins = (j_q == '0) || (mag33(corr) > mag33(best_corr_q));

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    best_index_d = best_index_q;
    best_corr_d  = best_corr_q;
    mac_clear    = 1'b0;
    mac_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          i_d       = '0;
          j_d       = '0;
          busy_d    = 1'b1;
          mac_clear = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      StLoad: begin
        // Data for row i-1 arrives while row i is being addressed.
        mac_en = (i_q != '0);
        if (i_q == SIG_AW'(M - 1)) begin
          state_d = StDrain;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      StDrain: begin
        mac_en  = 1'b1;
        state_d = StCompare;
      end
      StCompare: begin
        mac_clear = 1'b1;
        if (corr_wins) begin
          best_index_d = j_q;
          best_corr_d  = corr;
        end
        if (j_q == IDX_W'(N - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StLoad;
          j_d     = j_q + 1'b1;
          i_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      i_q          <= '0;
      j_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_index_q <= '0;
      best_corr_q  <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_index_q <= best_index_d;
      best_corr_q  <= best_corr_d;
    end
  end

  // Addresses follow the row/column counters, so they hold outside LOAD.
  assign dict_read_addr = DICT_AW'(j_q) * DICT_AW'(M) + DICT_AW'(i_q);
  assign r_read_addr    = i_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign best_index     = best_index_q;
  assign best_corr      = best_corr_q;

endmodule
